// File: rtl/vc_dest_arbiter.sv
// rtl/vc_dest_arbiter.sv - VC0/VC1 to D0/D1 arbiter with strict priority, starvation guard and 1-cycle push stage
module vc_dest_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  enable,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy
);

    logic [3:0]            starve_cnt;
    logic                  vc0_eligible;
    logic                  vc1_eligible;
    logic                  force1;
    logic                  grant0;
    logic                  grant1;
    logic [DATA_WIDTH-1:0] sel_word;

    // Reset gates eligibility so pops stay low while reset_L is asserted.
    assign vc0_eligible = reset_L & enable & ~vc0_empty &
                          ~(vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full);
    assign vc1_eligible = reset_L & enable & ~vc1_empty &
                          ~(vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full);

    assign force1   = (starve_cnt >= 4'(STARVE_MAX)) & vc1_eligible;
    assign grant1   = vc1_eligible & (force1 | ~vc0_eligible);
    assign grant0   = vc0_eligible & ~force1;
    assign sel_word = grant1 ? vc1_data : vc0_data;

    assign pop_vc0 = grant0;
    assign pop_vc1 = grant1;
    assign busy    = push_d0 | push_d1;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            starve_cnt <= 4'd0;
            push_d0    <= 1'b0;
            push_d1    <= 1'b0;
            data_out   <= '0;
        end else begin
            // With enable low the counter is frozen rather than cleared.
            if (enable) begin
                if (grant1 || !vc1_eligible)
                    starve_cnt <= 4'd0;
                else if (grant0 && starve_cnt != 4'd15)
                    starve_cnt <= starve_cnt + 4'd1;
            end
            if (grant0 || grant1) begin
                data_out <= sel_word;
                push_d1  <= sel_word[DEST_BIT];
                push_d0  <= ~sel_word[DEST_BIT];
            end else begin
                push_d0 <= 1'b0;
                push_d1 <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
- Sits between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1), downstream of the main-FIFO demux.
- Each cycle it selects at most one VC head word, pops it and pushes it one cycle later into the destination FIFO chosen by a destination bit in the word.
- VC0 has strict priority, with a starvation guard for VC1; destination almost-full flags provide backpressure.
- It runs only while the top-level control FSM reports active or idle operation without error.

Parameters:
- DATA_WIDTH, 6, width of a packet word.
- DEST_BIT, 4, bit index inside the word selecting destination (0 -> D0, 1 -> D1).
- STARVE_MAX, 4, consecutive VC0 grants allowed while VC1 is eligible before VC1 is forced a grant (range 1..15).

Ports:
- clk  input  1  clock, all logic on posedge.
- reset_L  input  1  synchronous active-low reset.
- enable  input  1  arbitration permitted (driven from the control FSM: active_out | idle_out, gated off on error).
- vc0_empty  input  1  VC0 FIFO empty.
- vc1_empty  input  1  VC1 FIFO empty.
- vc0_data  input  DATA_WIDTH  VC0 head word, first-word-fall-through, valid while vc0_empty=0.
- vc1_data  input  DATA_WIDTH  VC1 head word, same semantics.
- d0_almost_full  input  1  D0 almost-full flag.
- d1_almost_full  input  1  D1 almost-full flag.
- pop_vc0  output  1  pop VC0 head this cycle.
- pop_vc1  output  1  pop VC1 head this cycle.
- push_d0  output  1  push data_out into D0.
- push_d1  output  1  push data_out into D1.
- data_out  output  DATA_WIDTH  word being pushed.
- busy  output  1  a push is in flight (push_d0 | push_d1).

Behaviour:
- Reset (reset_L=0 at posedge): all outputs 0, starve counter 0, pipeline stage invalid. Reset mid-operation drops any in-flight word: no push after the reset edge.
- Eligibility (combinational): vcN_eligible = enable & ~vcN_empty & ~dX_almost_full, where X = vcN_data[DEST_BIT].
- Grant (combinational, same cycle):
  - force1 = (starve_cnt >= STARVE_MAX) & vc1_eligible.
  - If force1, grant VC1. Else if vc0_eligible, grant VC0. Else if vc1_eligible, grant VC1. Else no grant.
  - pop_vcN = grant to N. At most one pop per cycle; never pop an empty FIFO.
- Starve counter (registered, 4 bits):
  - +1 when VC0 is granted while vc1_eligible=1, saturating at 15.
  - Cleared when VC1 is granted or when vc1_eligible=0.
  - Holds when there is no grant and VC1 is eligible.
- Pipeline stage (registered, latency 1):
  - On the posedge after a grant: data_out <= granted head word; push_dX <= 1 for X = word[DEST_BIT]; the other push = 0.
  - Without a grant: both push = 0 and data_out holds its last value.
  - pop in cycle N -> push in cycle N+1. Back-to-back grants give one push per cycle.
- Backpressure: almost-full is sampled only at the grant cycle; an in-flight push always completes. Destination almost-full thresholds must leave at least 1 entry of slack.
- enable deassert: no new grants from that cycle; the in-flight push still completes on the next edge; the starve counter holds.
- Same head destination on both VCs with that destination almost-full: both ineligible, no pop, counter cleared.
- Simultaneous heads to different destinations: only one is served per cycle (single output pipeline).

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with both VCs non-empty -> all outputs 0; first pop_vc0 occurs in the first cycle after release (enable=1), and push follows 1 cycle later.
- Routing: VC0 holds 6'h10, 6'h01, VC1 empty, no almost-full -> pop_vc0 in cycles 1-2; push_d1 with data_out=6'h10, then push_d0 with data_out=6'h01 in cycles 2-3.
- Priority and starvation: both VCs hold 10 words to D0, STARVE_MAX=4 -> grant pattern VC0 x4, VC1 x1, repeating until VC0 empties.
- Backpressure: d1_almost_full=1, VC0 head dest=1, VC1 head dest=0 -> pop_vc1 only; after d1_almost_full drops, pop_vc0 occurs in the same cycle.
- Enable drop: enable falls in the same cycle as a pop -> no further pops; exactly one push on the next edge.
- Reset mid-flight: reset_L=0 in the cycle after a pop -> no push at that edge; outputs 0.
